// File: rtl/axi4_stream_pkt_pad.sv
// axi4_stream_pkt_pad
// AXI4-Stream stage that extends short packets to at least min_pkt_size_i bytes.
// Padding fills the free lanes of the tlast beat first. If more bytes are
// needed, the block then emits whole pad beats. Packets at or above the minimum
// pass through with data and sideband unchanged. There is one output register.
// Optional build macro: AXI4_STREAM_PKT_PAD_STAT_EN adds padded_pkt_cnt_o.
// Stream ports are flattened: pkt_i_<field> / pkt_o_<field>.
module axi4_stream_pkt_pad #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ID_WIDTH       = 1,
  parameter int         DEST_WIDTH     = 1,
  parameter int         USER_WIDTH     = 1,
  parameter int         MAX_PKT_SIZE_B = 2048,
  parameter int         PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B),
  parameter logic [7:0] PAD_BYTE       = 8'h00
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [PKT_SIZE_WIDTH:0]   min_pkt_size_i,
  // input stream
  input  logic                      pkt_i_tvalid,
  output logic                      pkt_i_tready,
  input  logic [DATA_WIDTH-1:0]     pkt_i_tdata,
  input  logic [DATA_WIDTH/8-1:0]   pkt_i_tkeep,
  input  logic [DATA_WIDTH/8-1:0]   pkt_i_tstrb,
  input  logic                      pkt_i_tlast,
  input  logic [ID_WIDTH-1:0]       pkt_i_tid,
  input  logic [DEST_WIDTH-1:0]     pkt_i_tdest,
  input  logic [USER_WIDTH-1:0]     pkt_i_tuser,
  // output stream
  output logic                      pkt_o_tvalid,
  input  logic                      pkt_o_tready,
  output logic [DATA_WIDTH-1:0]     pkt_o_tdata,
  output logic [DATA_WIDTH/8-1:0]   pkt_o_tkeep,
  output logic [DATA_WIDTH/8-1:0]   pkt_o_tstrb,
  output logic                      pkt_o_tlast,
  output logic [ID_WIDTH-1:0]       pkt_o_tid,
  output logic [DEST_WIDTH-1:0]     pkt_o_tdest,
  output logic [USER_WIDTH-1:0]     pkt_o_tuser
`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
  ,
  output logic [31:0]               padded_pkt_cnt_o
`endif
);

  localparam int             DB     = DATA_WIDTH / 8;
  localparam int             SW     = PKT_SIZE_WIDTH + 1;
  localparam logic [SW-1:0]  DB_SZ  = SW'(DB);
  localparam logic [SW-1:0]  MAX_SZ = SW'(MAX_PKT_SIZE_B);

  localparam logic [0:0] PASS_S = 1'b0;
  localparam logic [0:0] PAD_S  = 1'b1;

  // Number of valid lanes in a beat (lanes are contiguous from lane 0).
  function automatic logic [SW-1:0] popcnt(input logic [DB-1:0] m);
    logic [SW-1:0] c;
    c = '0;
    for (int l = 0; l < DB; l++) begin
      c = c + SW'(m[l]);
    end
    return c;
  endfunction

  // Byte-count accumulation that sticks at all-ones instead of wrapping.
  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SW] ? {SW{1'b1}} : s[SW-1:0];
  endfunction

  // Requests above the supported maximum are treated as the maximum.
  function automatic logic [SW-1:0] clamp_min(input logic [SW-1:0] m);
    return (m > MAX_SZ) ? MAX_SZ : m;
  endfunction

  // control state
  logic [0:0]            state_q,    state_d;
  logic [SW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]         pad_left_q, pad_left_d;
  logic                  first_q,    first_d;
  logic [SW-1:0]         min_q,      min_d;

  // output register
  logic                  o_valid_q, o_valid_d;
  logic                  o_last_q,  o_last_d;
  logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
  logic [DB-1:0]         o_keep_q,  o_keep_d;
  logic [DB-1:0]         o_strb_q,  o_strb_d;
  logic [ID_WIDTH-1:0]   o_id_q,    o_id_d;
  logic [DEST_WIDTH-1:0] o_dest_q,  o_dest_d;
  logic [USER_WIDTH-1:0] o_user_q,  o_user_d;

  // datapath helpers
  logic                  out_free;
  logic                  in_acc;
  logic [SW-1:0]         vb;
  logic [SW-1:0]         min_cur;
  logic [SW-1:0]         total;
  logic [SW-1:0]         need;
  logic [SW-1:0]         room;

  logic [DATA_WIDTH-1:0] pass_data;
  logic [DB-1:0]         pass_keep;
  logic [DB-1:0]         pass_strb;
  logic                  pass_last;
  logic                  pass_go_pad;
  logic [SW-1:0]         pass_pad_left;

  logic [DB-1:0]         pad_keep;
  logic                  pad_last;

  assign out_free     = !o_valid_q || pkt_o_tready;
  assign pkt_i_tready = (state_q == PASS_S) && out_free;
  assign in_acc       = pkt_i_tvalid && pkt_i_tready;

  assign vb      = popcnt(pkt_i_tkeep | pkt_i_tstrb);
  // The minimum is taken from the port only on a packet's first beat.
  assign min_cur = first_q ? clamp_min(min_pkt_size_i) : min_q;
  assign total   = sat_add(byte_cnt_q, vb);
  assign need    = (min_cur > total) ? (min_cur - total) : '0;
  assign room    = DB_SZ - vb;

  assign pkt_o_tvalid = o_valid_q;
  assign pkt_o_tlast  = o_last_q;
  assign pkt_o_tdata  = o_data_q;
  assign pkt_o_tkeep  = o_keep_q;
  assign pkt_o_tstrb  = o_strb_q;
  assign pkt_o_tid    = o_id_q;
  assign pkt_o_tdest  = o_dest_q;
  assign pkt_o_tuser  = o_user_q;

  // Shape an accepted input beat: pad the free lanes of a short tlast beat.
  always_comb begin
    pass_data     = pkt_i_tdata;
    pass_keep     = pkt_i_tkeep;
    pass_strb     = pkt_i_tstrb;
    pass_last     = pkt_i_tlast;
    pass_go_pad   = 1'b0;
    pass_pad_left = '0;
    if (pkt_i_tlast && (need != '0)) begin
      if (need > room) begin
        // The tlast beat cannot hold all the padding, so fill every free lane
        // and finish the packet with whole pad beats.
        pass_go_pad   = 1'b1;
        pass_last     = 1'b0;
        pass_pad_left = need - room;
      end
      for (int l = 0; l < DB; l++) begin
        if ((SW'(l) >= vb) && (pass_go_pad || (SW'(l) < (vb + need)))) begin
          pass_data[8*l +: 8] = PAD_BYTE;
          pass_keep[l]        = 1'b1;
          pass_strb[l]        = 1'b1;
        end
      end
    end
  end

  // Build the lane mask and last flag for the next pure pad beat.
  always_comb begin
    pad_keep = '0;
    for (int l = 0; l < DB; l++) begin
      pad_keep[l] = (SW'(l) < pad_left_q);
    end
    pad_last = (pad_left_q <= DB_SZ);
  end

  // Next-state logic for the packet tracker and the output register.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pad_left_d = pad_left_q;
    first_d    = first_q;
    min_d      = min_q;
    o_valid_d  = o_valid_q;
    o_last_d   = o_last_q;
    o_data_d   = o_data_q;
    o_keep_d   = o_keep_q;
    o_strb_d   = o_strb_q;
    o_id_d     = o_id_q;
    o_dest_d   = o_dest_q;
    o_user_d   = o_user_q;
    if (in_acc) begin
      min_d     = min_cur;
      o_valid_d = 1'b1;
      o_last_d  = pass_last;
      o_data_d  = pass_data;
      o_keep_d  = pass_keep;
      o_strb_d  = pass_strb;
      o_id_d    = pkt_i_tid;
      o_dest_d  = pkt_i_tdest;
      o_user_d  = pkt_i_tuser;
      if (pkt_i_tlast) begin
        byte_cnt_d = '0;
        first_d    = 1'b1;
        if (pass_go_pad) begin
          state_d    = PAD_S;
          pad_left_d = pass_pad_left;
        end
      end else begin
        byte_cnt_d = total;
        first_d    = 1'b0;
      end
    end else if (out_free) begin
      if (state_q == PAD_S) begin
        // Pad beats keep the sideband of the last input beat.
        o_valid_d = 1'b1;
        o_data_d  = {DB{PAD_BYTE}};
        o_keep_d  = pad_keep;
        o_strb_d  = pad_keep;
        o_last_d  = pad_last;
        if (pad_last) begin
          state_d    = PASS_S;
          pad_left_d = '0;
        end else begin
          pad_left_d = pad_left_q - DB_SZ;
        end
      end else begin
        o_valid_d = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= PASS_S;
      byte_cnt_q <= '0;
      pad_left_q <= '0;
      first_q    <= 1'b1;
      min_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pad_left_q <= pad_left_d;
      first_q    <= first_d;
      min_q      <= min_d;
    end
  end

  // Output register; cleared on reset so a dropped packet leaves nothing behind.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
      o_keep_q  <= '0;
      o_strb_q  <= '0;
      o_id_q    <= '0;
      o_dest_q  <= '0;
      o_user_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_data_q  <= o_data_d;
      o_keep_q  <= o_keep_d;
      o_strb_q  <= o_strb_d;
      o_id_q    <= o_id_d;
      o_dest_q  <= o_dest_d;
      o_user_q  <= o_user_d;
    end
  end

`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
  logic        padded_q, padded_d;
  logic [31:0] pcnt_q,   pcnt_d;

  assign padded_pkt_cnt_o = pcnt_q;

  // Track whether the beat in the output register belongs to an extended packet.
  always_comb begin
    padded_d = padded_q;
    pcnt_d   = pcnt_q;
    if (o_valid_q && pkt_o_tready && o_last_q && padded_q) begin
      pcnt_d = pcnt_q + 32'd1;
    end
    if (in_acc) begin
      padded_d = pkt_i_tlast && (need != '0);
    end else if (out_free && (state_q == PAD_S)) begin
      padded_d = 1'b1;
    end
  end

  // Padded-packet statistics registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      padded_q <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      padded_q <= padded_d;
      pcnt_q   <= pcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_pad.sv
// Self-checking bench for axi4_stream_pkt_pad (DATA_WIDTH=32, PAD_BYTE=8'hA5).
module tb_axi4_stream_pkt_pad;
  localparam int         DB   = 4;
  localparam int         MAXB = 2048;
  localparam logic [7:0] PAD  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] min_sz;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [3:0]  in_keep, in_strb;
  logic [0:0]  in_id, in_dest, in_user;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [3:0]  out_keep, out_strb;
  logic [0:0]  out_id, out_dest, out_user;
`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
  logic [31:0] pad_cnt;
`endif

  axi4_stream_pkt_pad #(.DATA_WIDTH(32), .PAD_BYTE(PAD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .min_pkt_size_i(min_sz),
    .pkt_i_tvalid(in_valid), .pkt_i_tready(in_ready), .pkt_i_tdata(in_data),
    .pkt_i_tkeep(in_keep), .pkt_i_tstrb(in_strb), .pkt_i_tlast(in_last),
    .pkt_i_tid(in_id), .pkt_i_tdest(in_dest), .pkt_i_tuser(in_user),
    .pkt_o_tvalid(out_valid), .pkt_o_tready(out_ready), .pkt_o_tdata(out_data),
    .pkt_o_tkeep(out_keep), .pkt_o_tstrb(out_strb), .pkt_o_tlast(out_last),
    .pkt_o_tid(out_id), .pkt_o_tdest(out_dest), .pkt_o_tuser(out_user)
`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
    , .padded_pkt_cnt_o(pad_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        id, dest, user;
    bit          no_in;
  } beat_t;

  typedef struct {
    int   mn;
    int   len;
    logic id, dest, user;
    bit   rnd;
    int   exp_beats;
  } tvec_t;

  beat_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  int          out_beats = 0;
  int          exp_pad_cnt = 0;
  bit          rdy_rand = 1'b0;
  logic [7:0]  pbytes[0:4095];
  logic [7:0]  garb[0:3];
  logic [31:0] prev_data;
  tvec_t       vec[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: packet bytes padded to max(len, clamped min), chunked into 4-byte beats.
  task automatic model_pkt(input int len, input int mn, input logic id, input logic dest, input logic user);
    int eff, total, nb, lastin, i;
    beat_t e;
    eff    = (mn > MAXB) ? MAXB : mn;
    total  = (len > eff) ? len : eff;
    nb     = (total + DB - 1) / DB;
    lastin = (len - 1) / DB;
    if (total > len) exp_pad_cnt++;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      e.keep = '0;
      for (int l = 0; l < DB; l++) begin
        i = b * DB + l;
        if (i < len) begin
          e.data[8*l +: 8] = pbytes[i];
          e.keep[l] = 1'b1;
        end else if (i < total) begin
          e.data[8*l +: 8] = PAD;
          e.keep[l] = 1'b1;
        end else if (b == lastin) begin
          e.data[8*l +: 8] = garb[l];
        end else begin
          e.data[8*l +: 8] = PAD;
        end
      end
      e.last  = (b == nb - 1);
      e.id    = id;
      e.dest  = dest;
      e.user  = user;
      e.no_in = (b >= lastin) && (b != nb - 1);
      sb.push_back(e);
    end
  endtask

  // Drive one packet; mn<0 keeps the current min, new_min>=0 changes it after beat 0.
  task automatic send_pkt(input int len, input int mn, input logic id, input logic dest,
                          input logic user, input int new_min, input bit chk_lat);
    int nb, waits, i;
    bit acc;
    for (int k = 0; k < len; k++) pbytes[k] = 8'($urandom);
    for (int l = 0; l < DB; l++) garb[l] = 8'($urandom);
    @(negedge clk);
    if (mn >= 0) min_sz = 12'(mn);
    model_pkt(len, int'(min_sz), id, dest, user);
    nb = (len + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      if (b > 0) @(negedge clk);
      for (int l = 0; l < DB; l++) begin
        i = b * DB + l;
        in_data[8*l +: 8] = (i < len) ? pbytes[i] : garb[l];
        in_keep[l] = (i < len);
      end
      in_strb  = in_keep;
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      in_id    = id;
      in_dest  = dest;
      in_user  = user;
      if (chk_lat && b > 0) begin
        #1;
        check("latency", 64'({out_valid, out_data}), 64'({1'b1, prev_data}));
      end
      waits = 0;
      forever begin
        #1;
        acc = in_ready;
        @(posedge clk);
        if (acc) break;
        @(negedge clk);
        waits++;
        if (waits > 5000) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: beat %0d not accepted after %0d cycles, expected acceptance", b, waits);
          in_valid = 1'b0;
          return;
        end
      end
      prev_data = in_data;
      if (chk_lat) check("no_gap", 64'(waits), 64'(0));
      #1;
      if (b == 0 && new_min >= 0) min_sz = 12'(new_min);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      #1;
      check("latency_last", 64'({out_valid, out_data}), 64'({1'b1, prev_data}));
    end
  endtask

  task automatic wait_drain(input string name, input int exp_beats);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    #2;
    check({name, "_beats"}, 64'(out_beats), 64'(exp_beats));
    out_beats = 0;
`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
    check({name, "_pad_cnt"}, 64'(pad_cnt), 64'(exp_pad_cnt));
`endif
  endtask

  // Output ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, no input accept while padding.
  initial begin
    beat_t       e;
    bit          stall;
    logic [43:0] held;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_hold", 64'({out_valid, out_data, out_keep, out_strb, out_last, out_id, out_dest, out_user}),
                64'({1'b1, held}));
          stall = 1'b0;
        end
        if (out_valid) begin
          if (sb.size() > 0 && sb[0].no_in) check("in_ready_in_pad", 64'(in_ready), 64'(0));
          if (out_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got data %h keep %b, expected no beat", out_data, out_keep);
            end else begin
              e = sb.pop_front();
              check("beat", 64'({out_data, out_keep, out_strb, out_last, out_id, out_dest, out_user}),
                    64'({e.data, e.keep, e.keep, e.last, e.id, e.dest, e.user}));
              out_beats++;
            end
          end else begin
            held  = {out_data, out_keep, out_strb, out_last, out_id, out_dest, out_user};
            stall = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    vec[0] = '{12,   10, 1'b0, 1'b1, 1'b0, 1'b0, 3};
    vec[1] = '{20,    5, 1'b1, 1'b0, 1'b1, 1'b1, 5};
    vec[2] = '{7,     1, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    vec[3] = '{8,     8, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vec[4] = '{9,     8, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    vec[5] = '{4095,  3, 1'b0, 1'b1, 1'b1, 1'b0, 512};
    vec[6] = '{6,    30, 1'b1, 1'b1, 1'b0, 1'b1, 8};
    vec[7] = '{16,   13, 1'b0, 1'b0, 1'b1, 1'b0, 4};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_strb  = '0;
    in_id    = '0;
    in_dest  = '0;
    in_user  = '0;
    min_sz   = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tvalid", 64'(out_valid), 64'(0));
    check("rst_fields", 64'({out_last, out_data, out_keep, out_strb, out_id, out_dest, out_user}), 64'(0));
    check("rst_tready", 64'(in_ready), 64'(1));
`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
    check("rst_pad_cnt", 64'(pad_cnt), 64'(0));
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through with min=0: identical data, 1-cycle latency, no input gaps.
    send_pkt(10, 0, 1'b1, 1'b0, 1'b1, -1, 1'b1);
    wait_drain("min0", 3);

    for (int v = 0; v < 8; v++) begin
      rdy_rand = vec[v].rnd;
      send_pkt(vec[v].len, vec[v].mn, vec[v].id, vec[v].dest, vec[v].user, -1, 1'b0);
      wait_drain($sformatf("vec%0d", v), vec[v].exp_beats);
      rdy_rand = 1'b0;
    end

    // Min changed mid-packet under random back-pressure: old min here, new min next.
    rdy_rand = 1'b1;
    send_pkt(6, 20, 1'b1, 1'b1, 1'b0, 8, 1'b0);
    wait_drain("old_min", 5);
    send_pkt(3, -1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    wait_drain("new_min", 2);
    rdy_rand = 1'b0;

    // Reset while emitting pad beats.
    send_pkt(2, 200, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(out_valid), 64'(0));
    check("midrst_fields", 64'({out_last, out_data, out_keep}), 64'(0));
`ifdef AXI4_STREAM_PKT_PAD_STAT_EN
    check("midrst_pad_cnt", 64'(pad_cnt), 64'(0));
`endif
    sb.delete();
    out_beats   = 0;
    exp_pad_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
    send_pkt(5, 20, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    wait_drain("after_rst", 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_stream_pkt_pad.md
Name: axi4_stream_pkt_pad

Overview:
- AXI4-Stream stage placed directly downstream of the packet splitter.
- Guarantees every output packet carries at least min_pkt_size_i bytes.
- Short packets are extended with a constant pad byte: first in the free lanes of the tlast beat, then in extra pad beats.
- Packets already at or above the minimum pass through with data and sideband unchanged. The block has one output register stage.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; multiple of 8.
- ID_WIDTH, 1, tid width.
- DEST_WIDTH, 1, tdest width.
- USER_WIDTH, 1, tuser width.
- MAX_PKT_SIZE_B, 2048, largest supported min_pkt_size_i value.
- PKT_SIZE_WIDTH, $clog2( MAX_PKT_SIZE_B ), width basis for size and counters.
- PAD_BYTE, 8'h00, value written into every pad byte.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset; asynchronous assert, active-low.
- min_pkt_size_i  input  PKT_SIZE_WIDTH+1  minimum packet length in bytes; 0 disables padding.
- pkt_i  axi4_stream_if (slave)  DATA_WIDTH  input stream.
- pkt_o  axi4_stream_if (master)  DATA_WIDTH  padded output stream.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n_i low forces all state immediately).
  - pkt_o.tvalid=0, tlast=0, tdata/tkeep/tstrb/tid/tdest/tuser=0.
  - State PASS_S, byte_cnt=0, pad_left=0, first-beat flag=1.
- Input format: tkeep/tstrb are contiguous from lane 0; a lane is valid if tkeep|tstrb. valid_bytes = popcount of valid lanes.
- Output register: pkt_i.tready = (state==PASS_S) && (!pkt_o.tvalid || pkt_o.tready). An accepted input beat appears on pkt_o on the next cycle. Full throughput with no bubbles while pkt_o.tready=1.
- Size sampling: min_pkt_size_i is latched on the first beat of each packet. Changes mid-packet do not affect that packet.
- byte_cnt (PKT_SIZE_WIDTH+1 bits) accumulates valid_bytes of accepted beats and saturates at all-ones. It clears after each accepted tlast beat.
- PASS_S, non-last beat: copied unchanged to the output register.
- PASS_S, tlast beat: total = byte_cnt + valid_bytes, need = min - total (0 if total >= min), room = DATA_WIDTH_B - valid_bytes.
  - need=0: beat copied unchanged, tlast=1.
  - 0<need<=room: lanes valid_bytes..valid_bytes+need-1 get PAD_BYTE with tkeep=tstrb=1; tlast=1; state stays PASS_S.
  - need>room: all free lanes padded, tkeep=tstrb all-ones, tlast=0; pad_left=need-room; go to PAD_S.
- PAD_S: pkt_i.tready=0. Each time the output register is free or being consumed, load one pad beat:
  - tdata all PAD_BYTE.
  - tkeep/tstrb = low min(pad_left, DATA_WIDTH_B) lanes set.
  - tid/tdest/tuser held from the last input beat.
  - tlast=1 when pad_left <= DATA_WIDTH_B; then return to PASS_S.
  - Otherwise pad_left -= DATA_WIDTH_B.
- Output stalls: pkt_o.tvalid=1 with pkt_o.tready=0 holds every pkt_o field stable.
- Single-beat packet with tfirst and tlast together: handled as a tlast beat with byte_cnt=0.
- min_pkt_size_i > MAX_PKT_SIZE_B is clamped to MAX_PKT_SIZE_B.
- Reset mid-packet: the packet is dropped and the output is cleared; the next beat after release is a first beat.

Optional Feature:
- Macro: AXI4_STREAM_PKT_PAD_STAT_EN.
- When defined: adds output padded_pkt_cnt_o (32 bits). It increments once per output packet whose length was extended, on the accepted output tlast beat. It wraps at 2^32 and resets to 0.
- When undefined: the port and counter do not exist. Data path behaviour is identical either way.

Test Plan (DATA_WIDTH=32):
- min=0, 3-beat packet with 10 bytes (last tkeep 4'b0011) -> output identical, 1-cycle latency, tready never gaps with pkt_o.tready=1.
- min=12, 10-byte packet -> last beat tkeep 4'b1111, bytes 2..3 = PAD_BYTE, tlast on that beat, no extra beats.
- min=20, 5-byte packet (tkeep 4'b1111 then 4'b0001, tlast) -> beat2 tkeep 4'b1111, tlast=0; pad beats tkeep 4'b1111 x2, then 4'b1111 with tlast; total 20 bytes; pkt_i.tready=0 during padding.
- min=7, single-beat 1-byte packet -> beat1 tkeep 4'b1111, pad beat tkeep 4'b0111 with tlast; pad beat tid/tdest/tuser equal input values.
- Random pkt_o.tready toggling during PAD_S plus min_pkt_size_i changed mid-packet -> outputs stable while stalled; the old min is used for the current packet and the new min for the next.
- Assert rst_n_i low in PAD_S -> pkt_o.tvalid drops immediately; the next packet after release is padded correctly; padded_pkt_cnt_o=0 (STAT_EN build).
